// File: rtl/filter_cfg_seq.sv
// filter_cfg_seq: configuration initiator for the stream filter datapath.
// Holds a host-loaded kernel table plus line width and rescale settings and
// replays them on start as an ordered burst on the cfg write bus:
// WIDTH (addr 1), optional idle gap, KER_NB x KERNEL (addr 2), RESCALE (addr 3).
// The upstream image stream is gated off while the filter is unconfigured or
// being reprogrammed.
// Optional build macro: FILTER_CFG_SEQ_CHECKSUM_EN adds the ker_sum output,
// a signed sum of the kernel coefficients accumulated during the burst.
`timescale 1ns/1ps

module filter_cfg_seq #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int MEM_AWIDTH = 16,
  parameter int IMG_WIDTH  = 16,
  parameter int KER_WIDTH  = 16,
  parameter int KER_NB     = 9,
  parameter int CFG_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ker_wr,
  input  logic [3:0]            ker_idx,
  input  logic [KER_WIDTH-1:0]  ker_data,
  input  logic [MEM_AWIDTH-1:0] width_val,
  input  logic [7:0]            shift,
  input  logic [7:0]            head,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  configured,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  input  logic [IMG_WIDTH-1:0]  up_img,
  input  logic                  up_img_val,
  output logic [IMG_WIDTH-1:0]  image,
  output logic                  image_val
`ifdef FILTER_CFG_SEQ_CHECKSUM_EN
  ,
  output logic [KER_WIDTH+3:0]  ker_sum
`endif
);

  // Config bus addresses of the three register groups in the filter.
  localparam logic [CFG_AWIDTH-1:0] ADDR_WIDTH   = CFG_AWIDTH'(1);
  localparam logic [CFG_AWIDTH-1:0] ADDR_KERNEL  = CFG_AWIDTH'(2);
  localparam logic [CFG_AWIDTH-1:0] ADDR_RESCALE = CFG_AWIDTH'(3);

  // Terminal counts; the gap counter is only used when CFG_GAP > 0.
  localparam int          GAP_LAST_I = (CFG_GAP > 0) ? CFG_GAP - 1 : 0;
  localparam logic [3:0]  GAP_LAST   = 4'(GAP_LAST_I);
  localparam logic [3:0]  KER_LAST   = 4'(KER_NB - 1);
  localparam logic [3:0]  KER_NB_IDX = 4'(KER_NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIDTH,
    S_GAP,
    S_KERNEL,
    S_RESCALE,
    S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic [3:0] ker_cnt_reg, ker_cnt_next;

  logic [7:0] shift_reg;
  logic [7:0] head_reg;

  logic                  cfg_valid_reg, cfg_valid_next;
  logic [CFG_AWIDTH-1:0] cfg_addr_reg, cfg_addr_next;
  logic [CFG_DWIDTH-1:0] cfg_data_reg, cfg_data_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  configured_reg, configured_next;

  logic [IMG_WIDTH-1:0] image_reg;
  logic                 image_val_reg;

  logic [KER_WIDTH-1:0] ker_tab [KER_NB];
  logic [KER_WIDTH-1:0] ker_rd;
  logic                 start_acc;
  logic                 ker_wr_en;

  // A start is only honoured from IDLE; anywhere else the burst is running.
  assign start_acc = start && (state_reg == S_IDLE);

  // Host writes are locked out while a burst is reading the table.
  assign ker_wr_en = ker_wr && !busy_reg && (ker_idx < KER_NB_IDX);

  // Coefficient presented on the bus for the next KERNEL beat.
  assign ker_rd = ker_tab[ker_cnt_next];

  // One register per kernel coefficient, each decoding its own index.
  for (genvar gi = 0; gi < KER_NB; gi++) begin : g_tab
    logic [KER_WIDTH-1:0] coef_reg;

    // Coefficient storage: loaded by the host, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        coef_reg <= '0;
      end else if (ker_wr_en && (ker_idx == 4'(gi))) begin
        coef_reg <= ker_data;
      end
    end

    assign ker_tab[gi] = coef_reg;
  end

  // FSM state and beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      gap_cnt_reg <= '0;
      ker_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      ker_cnt_reg <= ker_cnt_next;
    end
  end

  // Next-state sequencing of the burst.
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    ker_cnt_next = ker_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_WIDTH;
          gap_cnt_next = '0;
          ker_cnt_next = '0;
        end
      end
      S_WIDTH: begin
        if (CFG_GAP > 0) begin
          state_next   = S_GAP;
          gap_cnt_next = '0;
        end else begin
          state_next   = S_KERNEL;
          ker_cnt_next = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next   = S_KERNEL;
          ker_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      S_KERNEL: begin
        if (ker_cnt_reg == KER_LAST) begin
          state_next = S_RESCALE;
        end else begin
          ker_cnt_next = ker_cnt_reg + 4'd1;
        end
      end
      S_RESCALE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every bus output is a flop.
  always_comb begin
    cfg_valid_next  = 1'b0;
    cfg_addr_next   = '0;
    cfg_data_next   = '0;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    configured_next = configured_reg;
    case (state_next)
      S_WIDTH: begin
        // Only reachable straight from IDLE on start, so width_val here is
        // exactly the value captured by that start.
        cfg_valid_next = 1'b1;
        cfg_addr_next  = ADDR_WIDTH;
        cfg_data_next  = CFG_DWIDTH'(width_val);
        busy_next      = 1'b1;
      end
      S_GAP: begin
        busy_next = 1'b1;
      end
      S_KERNEL: begin
        cfg_valid_next = 1'b1;
        cfg_addr_next  = ADDR_KERNEL;
        cfg_data_next  = CFG_DWIDTH'(ker_rd);
        busy_next      = 1'b1;
      end
      S_RESCALE: begin
        cfg_valid_next = 1'b1;
        cfg_addr_next  = ADDR_RESCALE;
        cfg_data_next  = CFG_DWIDTH'({shift_reg, head_reg});
        busy_next      = 1'b1;
      end
      S_DONE: begin
        done_next       = 1'b1;
        configured_next = 1'b1;
      end
      default: ;
    endcase
    if (start_acc) begin
      configured_next = 1'b0;
    end
  end

  // Registered config bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid_reg  <= 1'b0;
      cfg_addr_reg   <= '0;
      cfg_data_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      configured_reg <= 1'b0;
    end else begin
      cfg_valid_reg  <= cfg_valid_next;
      cfg_addr_reg   <= cfg_addr_next;
      cfg_data_reg   <= cfg_data_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      configured_reg <= configured_next;
    end
  end

  // Rescale settings are held for the RESCALE beat at the end of the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      head_reg  <= '0;
    end else if (start_acc) begin
      shift_reg <= shift;
      head_reg  <= head;
    end
  end

  // Image gate: pixels are dropped unless the filter is configured and idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_reg     <= '0;
      image_val_reg <= 1'b0;
    end else begin
      image_reg     <= up_img;
      image_val_reg <= up_img_val && configured_reg && !busy_reg;
    end
  end

`ifdef FILTER_CFG_SEQ_CHECKSUM_EN
  logic [KER_WIDTH+3:0] ker_sum_reg;

  // Signed running sum of the coefficients as each KERNEL beat is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ker_sum_reg <= '0;
    end else if (start_acc) begin
      ker_sum_reg <= '0;
    end else if (state_next == S_KERNEL) begin
      ker_sum_reg <= ker_sum_reg + {{4{ker_rd[KER_WIDTH-1]}}, ker_rd};
    end
  end

  assign ker_sum = ker_sum_reg;
`endif

  assign cfg_valid  = cfg_valid_reg;
  assign cfg_addr   = cfg_addr_reg;
  assign cfg_data   = cfg_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign configured = configured_reg;
  assign image      = image_reg;
  assign image_val  = image_val_reg;

endmodule

// File: tb/tb_filter_cfg_seq.sv
// tb_filter_cfg_seq: directed stimulus with a scoreboard. Stimulus pushes the
// expected config-bus beats (and gated pixels) into queues; negedge monitors
// pop and compare whenever the DUT presents cfg_valid/done or a tracked pixel.
`timescale 1ns/1ps

module tb_filter_cfg_seq;

  localparam int CFG_DWIDTH = 32;
  localparam int CFG_AWIDTH = 5;
  localparam int MEM_AWIDTH = 16;
  localparam int IMG_WIDTH  = 16;
  localparam int KER_WIDTH  = 16;
  localparam int KER_NB     = 9;
  localparam int CFG_GAP    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ker_wr = 1'b0;
  logic [3:0]            ker_idx = '0;
  logic [KER_WIDTH-1:0]  ker_data = '0;
  logic [MEM_AWIDTH-1:0] width_val = '0;
  logic [7:0]            shift = '0;
  logic [7:0]            head = '0;
  logic                  start = 1'b0;
  logic                  busy;
  logic                  done;
  logic                  configured;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic [IMG_WIDTH-1:0]  up_img = '0;
  logic                  up_img_val = 1'b0;
  logic [IMG_WIDTH-1:0]  image;
  logic                  image_val;
`ifdef FILTER_CFG_SEQ_CHECKSUM_EN
  logic [KER_WIDTH+3:0]  ker_sum;
`endif

  filter_cfg_seq #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .MEM_AWIDTH(MEM_AWIDTH),
    .IMG_WIDTH(IMG_WIDTH), .KER_WIDTH(KER_WIDTH), .KER_NB(KER_NB), .CFG_GAP(CFG_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ker_wr(ker_wr), .ker_idx(ker_idx), .ker_data(ker_data),
    .width_val(width_val), .shift(shift), .head(head), .start(start),
    .busy(busy), .done(done), .configured(configured),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .up_img(up_img), .up_img_val(up_img_val), .image(image), .image_val(image_val)
`ifdef FILTER_CFG_SEQ_CHECKSUM_EN
    , .ker_sum(ker_sum)
`endif
  );

  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit                    is_done;
    logic [CFG_AWIDTH-1:0] addr;
    logic [CFG_DWIDTH-1:0] data;
    int                    cyc;
  } cfg_exp_t;

  typedef struct {
    int                   cyc;
    logic                 val;
    logic [IMG_WIDTH-1:0] data;
  } img_exp_t;

  cfg_exp_t cfg_q[$];
  img_exp_t img_q[$];
  logic [KER_WIDTH-1:0] model_tab [KER_NB];

  // Upstream pixel pattern: the pixel driven during cycle c.
  function automatic logic [IMG_WIDTH-1:0] img_f(input int c);
    return IMG_WIDTH'(c * 37 + 5);
  endfunction

  always @(negedge clk) up_img = img_f(cyc);

  // Config bus monitor.
  cfg_exp_t ce;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_valid || done) begin
        n_checks++;
        if (cfg_q.size() == 0) begin
          n_fail++;
          $display("FAIL cfg_unexpected cyc=%0d actual valid=%0b done=%0b addr=%0d data=%0h required no beat",
                   cyc, cfg_valid, done, cfg_addr, cfg_data);
        end else begin
          ce = cfg_q.pop_front();
          if (cyc != ce.cyc || cfg_valid !== !ce.is_done || done !== ce.is_done ||
              busy !== !ce.is_done || cfg_addr !== ce.addr || cfg_data !== ce.data) begin
            n_fail++;
            $display("FAIL cfg_beat actual cyc=%0d v=%0b d=%0b busy=%0b addr=%0d data=%0h required cyc=%0d d=%0b addr=%0d data=%0h",
                     cyc, cfg_valid, done, busy, cfg_addr, cfg_data, ce.cyc, ce.is_done, ce.addr, ce.data);
          end else begin
            $display("cfg ok cyc=%0d done=%0b addr=%0d data=%0h", cyc, done, cfg_addr, cfg_data);
          end
        end
      end else if (cfg_addr !== '0 || cfg_data !== '0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cfg_idle_zero cyc=%0d actual addr=%0d data=%0h required 0", cyc, cfg_addr, cfg_data);
      end
    end
  end

  // Gated pixel monitor.
  img_exp_t ie;
  always @(negedge clk) begin
    if (img_q.size() > 0 && img_q[0].cyc == cyc) begin
      ie = img_q.pop_front();
      n_checks++;
      if (image_val !== ie.val || (ie.val && image !== ie.data)) begin
        n_fail++;
        $display("FAIL image cyc=%0d actual val=%0b data=%0h required val=%0b data=%0h",
                 cyc, image_val, image, ie.val, ie.data);
      end else begin
        $display("img ok cyc=%0d val=%0b data=%0h", cyc, image_val, image);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("chk ok %s = %0h", name, act);
    end
  endtask

  task automatic push_one(input bit d, input logic [CFG_AWIDTH-1:0] a,
                          input logic [CFG_DWIDTH-1:0] v, input int c, input int cutoff);
    cfg_exp_t e;
    e.is_done = d;
    e.addr    = a;
    e.data    = v;
    e.cyc     = c;
    if (c <= cutoff) cfg_q.push_back(e);
  endtask

  // Expected burst for a start driven during cycle t; beats after cutoff are dropped.
  task automatic push_burst(input int t, input logic [15:0] w, input logic [7:0] sh,
                            input logic [7:0] hd, input int cutoff);
    push_one(1'b0, 5'd1, 32'(w), t + 1, cutoff);
    for (int k = 0; k < KER_NB; k++)
      push_one(1'b0, 5'd2, 32'(model_tab[k]), t + 2 + CFG_GAP + k, cutoff);
    push_one(1'b0, 5'd3, {16'h0, sh, hd}, t + 11 + CFG_GAP, cutoff);
    push_one(1'b1, 5'd0, 32'h0, t + 12 + CFG_GAP, cutoff);
  endtask

  task automatic ker_write(input int idx, input logic [15:0] d);
    @(negedge clk);
    ker_wr   = 1'b1;
    ker_idx  = idx[3:0];
    ker_data = d;
    @(negedge clk);
    ker_wr   = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] w, input logic [7:0] sh, input logic [7:0] hd,
                          input int cutoff_rel, output int t);
    @(negedge clk);
    start     = 1'b1;
    width_val = w;
    shift     = sh;
    head      = hd;
    t         = cyc;
    push_burst(t, w, sh, hd, t + cutoff_rel);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    img_exp_t ix;

    for (int k = 0; k < KER_NB; k++) model_tab[k] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'h0);
    chk("rst_cfg_addr", 32'(cfg_addr), 32'h0);
    chk("rst_cfg_data", cfg_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_configured", 32'(configured), 32'h0);
    chk("rst_image_val", 32'(image_val), 32'h0);
    chk("rst_image", 32'(image), 32'h0);
    rst_n = 1'b1;

    // Scenario 1: table k+1, width 640, shift 4, head 0x10.
    for (int k = 0; k < KER_NB; k++) begin
      ker_write(k, 16'(k + 1));
      model_tab[k] = 16'(k + 1);
    end
    do_start(16'd640, 8'd4, 8'h10, 100, t);
    wait_cyc(t + 16);
    chk("s1_configured", 32'(configured), 32'h1);
    chk("s1_busy", 32'(busy), 32'h0);

    // Scenario 2: continuous pixels across a reprogramming burst.
    @(negedge clk);
    up_img_val = 1'b1;
    @(negedge clk);
    do_start(16'd640, 8'd4, 8'h10, 100, t);
    for (int n = t + 1; n <= t + 16; n++) begin
      ix.cyc  = n;
      ix.val  = (n == t + 1) || (n >= t + 15);
      ix.data = img_f(n - 1);
      img_q.push_back(ix);
    end
    wait_cyc(t + 17);
    up_img_val = 1'b0;

    // Scenario 3: start and a table write while busy are both ignored.
    do_start(16'd800, 8'd2, 8'd3, 100, t);
    wait_cyc(t + 5);
    start    = 1'b1;
    ker_wr   = 1'b1;
    ker_idx  = 4'd3;
    ker_data = 16'hFFFF;
    @(negedge clk);
    start    = 1'b0;
    ker_wr   = 1'b0;
    wait_cyc(t + 16);

    // Scenario 4: out-of-range index is ignored; table still holds k+1.
    ker_write(9, 16'h1234);
    do_start(16'd1024, 8'h07, 8'hFF, 100, t);
    wait_cyc(t + 16);

    // Scenario 5: asynchronous reset mid-burst aborts everything.
    do_start(16'd320, 8'd1, 8'd2, 6, t);
    wait_cyc(t + 6);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cfg_valid", 32'(cfg_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_configured", 32'(configured), 32'h0);
    for (int k = 0; k < KER_NB; k++) model_tab[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_configured", 32'(configured), 32'h0);
    chk("post_abort_busy", 32'(busy), 32'h0);

    // Scenario 6: reset cleared the table, so the kernel beats are all zero.
    do_start(16'd1920, 8'hA5, 8'h3C, 100, t);
    wait_cyc(t + 16);
    chk("s6_configured", 32'(configured), 32'h1);

`ifdef FILTER_CFG_SEQ_CHECKSUM_EN
    // Checksum: Laplacian-style kernel sums to 0, table k+1 sums to 45.
    for (int k = 0; k < KER_NB; k++) begin
      ker_write(k, (k == 4) ? 16'h0008 : 16'hFFFF);
      model_tab[k] = (k == 4) ? 16'h0008 : 16'hFFFF;
    end
    do_start(16'd64, 8'd0, 8'd0, 100, t);
    wait_cyc(t + 14);
    chk("sum_laplace", 32'(ker_sum), 32'h0);
    wait_cyc(t + 16);
    for (int k = 0; k < KER_NB; k++) begin
      ker_write(k, 16'(k + 1));
      model_tab[k] = 16'(k + 1);
    end
    do_start(16'd64, 8'd0, 8'd0, 100, t);
    wait_cyc(t + 14);
    chk("sum_k1", 32'(ker_sum), 32'd45);
    wait_cyc(t + 17);
    chk("sum_held", 32'(ker_sum), 32'd45);
    do_start(16'd64, 8'd0, 8'd0, 100, t);
    chk("sum_cleared", 32'(ker_sum), 32'h0);
    wait_cyc(t + 16);
`endif

    repeat (4) @(negedge clk);
    chk("cfg_queue_drained", 32'(cfg_q.size()), 32'h0);
    chk("img_queue_drained", 32'(img_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_cfg_seq.md
Name: filter_cfg_seq

Overview:
- Configuration initiator for the stream filter datapath.
- Holds a host-loaded 3x3 kernel table plus line width and rescale settings, and replays them on start as an ordered burst on the cfg_data/cfg_addr/cfg_valid write bus: WIDTH, then 9 KERNEL writes, then RESCALE.
- Gates the upstream image stream so that no pixel reaches the filter while the filter is unconfigured or being reprogrammed.

Parameters:
- CFG_DWIDTH, 32, config bus data width.
- CFG_AWIDTH, 5, config bus address width.
- MEM_AWIDTH, 16, line-width (delay) field width.
- IMG_WIDTH, 16, pixel width.
- KER_WIDTH, 16, kernel coefficient width.
- KER_NB, 9, number of kernel coefficients.
- CFG_GAP, 2, idle cycles inserted after the WIDTH write. Legal range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ker_wr  in  1  kernel table write strobe.
- ker_idx  in  4  kernel table index.
- ker_data  in  KER_WIDTH  kernel coefficient.
- width_val  in  MEM_AWIDTH  line width to program.
- shift  in  8  rescale shift.
- head  in  8  rescale head.
- start  in  1  begin a config burst (single-cycle pulse).
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst completes.
- configured  out  1  filter holds a valid configuration.
- cfg_data  out  CFG_DWIDTH  config write data.
- cfg_addr  out  CFG_AWIDTH  config write address.
- cfg_valid  out  1  config write strobe.
- up_img  in  IMG_WIDTH  upstream pixel.
- up_img_val  in  1  upstream pixel valid.
- image  out  IMG_WIDTH  gated pixel to filter.
- image_val  out  1  gated pixel valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0; state is IDLE.
  - Kernel table, captured width/shift/head, and gap counter are all 0.
  - A reset mid-burst aborts the burst: no further cfg_valid, no done pulse, configured stays 0.
- Kernel table:
  - A ker_wr with ker_idx < KER_NB writes table[ker_idx] on the clock edge.
  - ker_idx >= KER_NB is ignored.
  - Writes while busy=1 are ignored.
  - A write in the same cycle as an accepted start is applied and is used by that burst.
- FSM states: IDLE, WIDTH, GAP, KERNEL, RESCALE, DONE.
- IDLE:
  - start=1 captures width_val/shift/head, clears configured, goes to WIDTH.
  - start while busy=1 is ignored.
- WIDTH (one cycle):
  - cfg_valid=1, cfg_addr=1, cfg_data=width_val zero-extended.
  - Goes to GAP if CFG_GAP>0, else to KERNEL.
- GAP: cfg_valid=0 for exactly CFG_GAP cycles, then KERNEL.
- KERNEL:
  - KER_NB consecutive cycles with cfg_valid=1, cfg_addr=2.
  - cfg_data = table[k] zero-extended, k = 0..KER_NB-1 in ascending order.
- RESCALE (one cycle): cfg_valid=1, cfg_addr=3, cfg_data={zeros, shift[7:0] at bits 15:8, head[7:0] at bits 7:0}.
- DONE (one cycle): done=1, configured set to 1, cfg_valid=0, then IDLE.
- Timing:
  - All cfg outputs are registered.
  - For start accepted at edge T, busy=1 and the WIDTH write appear from T+1.
  - The RESCALE write appears at T+11+CFG_GAP.
  - done is asserted at T+12+CFG_GAP with busy=0.
  - When cfg_valid=0, cfg_data and cfg_addr are 0.
- Image gate:
  - Registered, 1-cycle latency.
  - image <= up_img every cycle.
  - image_val <= up_img_val & configured & ~busy.
  - Pixels arriving while gated are dropped, not buffered.
  - Gating takes effect the cycle after start is accepted.

Optional Feature:
- FILTER_CFG_SEQ_CHECKSUM_EN, when defined:
  - Adds output ker_sum [KER_WIDTH+3:0]: the signed sum of table[0..KER_NB-1], accumulated during KERNEL writes.
  - ker_sum is valid, and held, from the done cycle until the next accepted start. It clears to 0 on start and on reset.
- When not defined: no ker_sum port and no accumulator logic.

Test Plan:
- Reset, load table[k]=k+1, width_val=640, shift=4, head=0x10, CFG_GAP=2, start at T -> cfg writes (1,640)@T+1, (2,1..9)@T+4..T+12, (3,0x0410)@T+13; done@T+14; configured=1.
- Continuous up_img_val=1 across a start -> image_val=0 from T+2 through T+14; image_val resumes at T+15 with image = up_img delayed 1 cycle.
- start pulsed at T+5 during a burst, plus ker_wr idx 3 data 0xFFFF during busy -> sequence unchanged, table[3] still 4.
- ker_wr with ker_idx=9 data 0x1234, then start -> all KERNEL writes show only the values from the first scenario; no 0x1234.
- rst_n asserted low at T+6 mid-burst -> cfg_valid, busy, done, configured are 0 immediately; after release, no writes occur until a new start.
- With FILTER_CFG_SEQ_CHECKSUM_EN, table = {-1,-1,-1,-1,8,-1,-1,-1,-1} -> ker_sum=0 at done; with table k+1 -> ker_sum=45.
